// File: rtl/apb_rtl_pkg.sv
// Shared APB completer types: bus widths, FSM states, decode result.
package apb_rtl_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } apb_cmp_state_e;

    typedef struct packed {
        logic [5:0] idx;
        logic       err;
    } apb_decode_t;

endpackage

// File: rtl/apb_completer_decode.sv
// APB byte address to register index decode with error flag.
module apb_completer_decode
    import apb_rtl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_REGS  = 8
) (
    input  logic [APB_ADDR_W-1:0] PADDR,
    output apb_decode_t           dec
);

    logic [31:0] offset;
    logic [29:0] word;

    assign offset = PADDR - BASE_ADDR;
    assign word   = offset[31:2];

    always_comb begin
        dec.idx = word[5:0];
        dec.err = (PADDR < BASE_ADDR)
               || (offset[1:0] != 2'b00)
               || (word >= 30'(NUM_REGS));
    end

endmodule

// File: rtl/apb_completer_regfile.sv
// APB3 completer fronting a bank of 32-bit registers with
// programmable wait states and PSLVERR on bad addresses.
module apb_completer_regfile
    import apb_rtl_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] RESET_VAL   = 32'h0
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic [APB_ADDR_W-1:0]    PADDR,
    input  logic [APB_DATA_W-1:0]    PWDATA,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    output logic [APB_DATA_W-1:0]    PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

    localparam logic [3:0] CNT_INIT =
        4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    apb_cmp_state_e state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           wr_q;
    logic [31:0]    wdata_q;
    apb_decode_t    dec, dec_q, cur;
    logic           cur_wr;

    logic                ready_d, slverr_d;
    logic [31:0]         rdata_d, rd_mux;
    logic [NUM_REGS-1:0] pulse_d;
    logic                capture, respond, commit;
    logic                setup, access;

    logic [31:0] regs [NUM_REGS];

    apb_completer_decode #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS)
    ) u_dec (
        .PADDR (PADDR),
        .dec   (dec)
    );

    assign setup  = PSEL & ~PENABLE;
    assign access = PSEL & PENABLE;

    // Zero-wait completion responds on the setup edge itself,
    // so IDLE uses the live decode rather than the captured one.
    assign cur    = (state_q == IDLE) ? dec : dec_q;
    assign cur_wr = (state_q == IDLE) ? PWRITE : wr_q;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cur.idx == 6'(i)) rd_mux = regs[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = 1'b0;
        slverr_d = 1'b0;
        rdata_d  = '0;
        pulse_d  = '0;
        capture  = 1'b0;
        respond  = 1'b0;
        commit   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        respond = 1'b1;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    if (cnt_q == 4'd0) begin
                        state_d = RESP;
                        respond = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                commit  = access & PREADY & cur_wr & ~cur.err;
            end
            default: state_d = IDLE;
        endcase
        if (respond) begin
            ready_d  = 1'b1;
            slverr_d = cur.err;
            rdata_d  = (cur_wr || cur.err) ? 32'h0 : rd_mux;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            pulse_d[i] = commit && (cur.idx == 6'(i));
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            dec_q      <= '0;
            PREADY     <= 1'b0;
            PSLVERR    <= 1'b0;
            PRDATA     <= '0;
            wr_pulse_o <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            PREADY     <= ready_d;
            PSLVERR    <= slverr_d;
            PRDATA     <= rdata_d;
            wr_pulse_o <= pulse_d;
            if (capture) begin
                wr_q    <= PWRITE;
                wdata_q <= PWDATA;
                dec_q   <= dec;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (pulse_d[i]) regs[i] <= wdata_q;
            end
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[32*i +: 32] = regs[i];
        end
    end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Randomized APB completer bench: three instances with 0/3/5 wait
// states, checked against an array model of the register bank.
module tb_apb_completer_regfile;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] PADDR, PWDATA;
    logic        PENABLE, PWRITE;
    logic [2:0]  psel;

    logic [31:0]  prdata [3];
    logic         pready [3];
    logic         pslverr[3];
    logic [255:0] regs   [3];
    logic [7:0]   pulse  [3];

    int n_run  = 0;
    int n_fail = 0;
    logic [31:0] mdl [3][8];

    always #5 PCLK = ~PCLK;

    apb_completer_regfile #(
        .NUM_REGS(8), .BASE_ADDR(32'h0000_0000),
        .WAIT_STATES(0), .RESET_VAL(32'h0)
    ) u0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSEL(psel[0]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PRDATA(prdata[0]), .PREADY(pready[0]),
        .PSLVERR(pslverr[0]), .regs_o(regs[0]),
        .wr_pulse_o(pulse[0])
    );

    apb_completer_regfile #(
        .NUM_REGS(8), .BASE_ADDR(32'h0000_1000),
        .WAIT_STATES(3), .RESET_VAL(32'hA5A5_0000)
    ) u3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSEL(psel[1]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PRDATA(prdata[1]), .PREADY(pready[1]),
        .PSLVERR(pslverr[1]), .regs_o(regs[1]),
        .wr_pulse_o(pulse[1])
    );

    apb_completer_regfile #(
        .NUM_REGS(8), .BASE_ADDR(32'h0000_0200),
        .WAIT_STATES(5), .RESET_VAL(32'h1234_5678)
    ) u5 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSEL(psel[2]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PRDATA(prdata[2]), .PREADY(pready[2]),
        .PSLVERR(pslverr[2]), .regs_o(regs[2]),
        .wr_pulse_o(pulse[2])
    );

    function automatic logic [31:0] base_of(input int d);
        case (d)
            0:       return 32'h0000_0000;
            1:       return 32'h0000_1000;
            default: return 32'h0000_0200;
        endcase
    endfunction

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 3;
            default: return 5;
        endcase
    endfunction

    function automatic logic [31:0] rv_of(input int d);
        case (d)
            0:       return 32'h0;
            1:       return 32'hA5A5_0000;
            default: return 32'h1234_5678;
        endcase
    endfunction

    function automatic logic [255:0] mdl_vec(input int d);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = mdl[d][i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 8; i++) mdl[d][i] = rv_of(d);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle_bus();
        psel    = '0;
        PENABLE = 1'b0;
    endtask

    task automatic xfer(input int d, input logic [31:0] addr,
                        input bit wr, input logic [31:0] wd,
                        input bit b2b);
        logic [31:0] off, exp_rd;
        logic [7:0]  exp_pl;
        bit          err;
        int          idx, waits;
        off    = addr - base_of(d);
        err    = (addr < base_of(d)) || (off % 4 != 0) || (off / 4 >= 8);
        idx    = err ? 0 : int'(off / 4);
        exp_rd = (wr || err) ? 32'h0 : mdl[d][idx];
        exp_pl = (wr && !err) ? 8'(1 << idx) : 8'h0;
        psel    = 3'(1 << d);
        PENABLE = 1'b0;
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = wd;
        tick();
        PENABLE = 1'b1;
        waits   = 0;
        while (!pready[d] && waits < 40) begin
            tick();
            waits++;
        end
        chk("wait_cycles", 256'(waits), 256'(ws_of(d)));
        chk("pslverr", 256'(pslverr[d]), 256'(err));
        chk("prdata", 256'(prdata[d]), 256'(exp_rd));
        if (wr && !err) mdl[d][idx] = wd;
        tick();
        chk("pready_clr", 256'(pready[d]), 256'(0));
        chk("prdata_clr", 256'(prdata[d]), 256'(0));
        chk("wr_pulse", 256'(pulse[d]), 256'(exp_pl));
        chk("regs", regs[d], mdl_vec(d));
        if (!b2b) begin
            idle_bus();
            tick();
            chk("wr_pulse_end", 256'(pulse[d]), 256'(0));
        end
    endtask

    task automatic chk_reset_state();
        for (int d = 0; d < 3; d++) begin
            chk("rst_pready", 256'(pready[d]), 256'(0));
            chk("rst_pslverr", 256'(pslverr[d]), 256'(0));
            chk("rst_prdata", 256'(prdata[d]), 256'(0));
            chk("rst_pulse", 256'(pulse[d]), 256'(0));
            chk("rst_regs", regs[d], mdl_vec(d));
        end
    endtask

    initial begin
        PRESETn = 1'b0;
        psel    = '0;
        PENABLE = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        PWRITE  = 1'b0;
        mdl_reset();
        repeat (3) tick();
        chk_reset_state();
        PRESETn = 1'b1;
        tick();

        // reset contents, zero-wait reads
        for (int i = 0; i < 8; i++) xfer(0, 32'(4 * i), 1'b0, 32'h0, 1'b0);

        // three wait states, write then read back
        xfer(1, 32'h1008, 1'b1, 32'hDEAD_BEEF, 1'b0);
        xfer(1, 32'h1008, 1'b0, 32'h0, 1'b0);

        // bad addresses
        xfer(1, 32'h1020, 1'b1, 32'h1111_1111, 1'b0);
        xfer(1, 32'h1006, 1'b1, 32'h2222_2222, 1'b0);
        xfer(1, 32'h0FFC, 1'b1, 32'h3333_3333, 1'b0);
        xfer(0, 32'h0000_0020, 1'b0, 32'h0, 1'b0);

        // back-to-back write then read, no idle cycle
        xfer(0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b1);
        xfer(0, 32'h0, 1'b0, 32'h0, 1'b0);

        // access phase with no setup is ignored
        psel    = 3'b001;
        PENABLE = 1'b1;
        PADDR   = 32'h4;
        PWRITE  = 1'b1;
        PWDATA  = 32'hBAD0_BAD0;
        repeat (3) begin
            tick();
            chk("no_setup_pready", 256'(pready[0]), 256'(0));
        end
        idle_bus();
        tick();
        chk("no_setup_regs", regs[0], mdl_vec(0));

        // abort during wait states
        xfer(2, 32'h208, 1'b1, 32'h5555_AAAA, 1'b0);
        psel    = 3'b100;
        PENABLE = 1'b0;
        PADDR   = 32'h208;
        PWRITE  = 1'b1;
        PWDATA  = 32'h0BAD_0BAD;
        tick();
        PENABLE = 1'b1;
        repeat (2) begin
            tick();
            chk("abort_pready", 256'(pready[2]), 256'(0));
        end
        idle_bus();
        repeat (6) begin
            tick();
            chk("abort_pready_after", 256'(pready[2]), 256'(0));
        end
        chk("abort_regs", regs[2], mdl_vec(2));
        chk("abort_pulse", 256'(pulse[2]), 256'(0));

        // asynchronous reset in the middle of a write
        psel    = 3'b100;
        PENABLE = 1'b0;
        PWDATA  = 32'h7777_8888;
        tick();
        PENABLE = 1'b1;
        tick();
        tick();
        PRESETn = 1'b0;
        #2;
        mdl_reset();
        chk_reset_state();
        idle_bus();
        tick();
        PRESETn = 1'b1;
        tick();
        chk("post_rst_regs", regs[2], mdl_vec(2));
        xfer(2, 32'h208, 1'b0, 32'h0, 1'b0);
        xfer(2, 32'h208, 1'b1, 32'h0F0F_F0F0, 1'b0);

        // randomized traffic across all three completers
        for (int k = 0; k < 150; k++) begin
            int          d;
            logic [31:0] a;
            bit          w, b;
            d = $urandom_range(0, 2);
            a = base_of(d) + 32'($urandom_range(0, 44)) - 32'd4;
            w = 1'($urandom_range(0, 1));
            b = (k < 149) && ($urandom_range(0, 1) == 1);
            xfer(d, a, w, $urandom, b);
        end
        idle_bus();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
